// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision float constants and the converter state type.
package fp_pkg;
  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 32;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;
endpackage

// File: rtl/fp_round_ne.sv
// fp_round_ne: round-to-nearest-even on a 23-bit mantissa, bumping the exponent on carry-out.
module fp_round_ne
  import fp_pkg::*;
(
  input  logic [FP_MAN_W-1:0] man_i,
  input  logic                guard_i,
  input  logic                sticky_i,
  input  logic [FP_EXP_W-1:0] exp_i,
  output logic [FP_MAN_W-1:0] man_o,
  output logic [FP_EXP_W-1:0] exp_o
);
  logic            up;
  logic [FP_MAN_W:0] sum;
  assign up    = guard_i & (sticky_i | man_i[0]);
  assign sum   = {1'b0, man_i} + {{FP_MAN_W{1'b0}}, up};
  // On carry-out the low bits are already zero, i.e. mantissa 1.0 of the next binade.
  assign man_o = sum[FP_MAN_W-1:0];
  assign exp_o = exp_i + {{(FP_EXP_W-1){1'b0}}, sum[FP_MAN_W]};
endmodule

// File: rtl/itofp_seq.sv
// itofp_seq: sequential signed 32-bit integer to IEEE-754 single conversion, one bit of normalisation per cycle.
module itofp_seq
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data
);
  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [FP_W-1:0]       mag_q, mag_d;
  logic [FP_EXP_W-1:0]   exp_q, exp_d;
  logic [FP_W-1:0]       data_q, data_d;
  logic [FP_W-1:0]       abs_in;
  logic [FP_MAN_W-1:0]   rnd_man;
  logic [FP_EXP_W-1:0]   rnd_exp;
  // Negating 0x80000000 wraps to itself, which is exactly the magnitude wanted.
  assign abs_in = in_data[FP_W-1] ? -in_data : in_data;
  fp_round_ne u_round (
    .man_i   (mag_q[30:8]),
    .guard_i (mag_q[7]),
    .sticky_i(|mag_q[6:0]),
    .exp_i   (exp_q),
    .man_o   (rnd_man),
    .exp_o   (rnd_exp)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d  = in_data[FP_W-1];
        mag_d   = abs_in;
        exp_d   = FP_EXP_W'(FP_BIAS + FP_W - 1);
        state_d = (abs_in == '0) ? DONE : NORM;
        data_d  = (abs_in == '0) ? '0 : data_q;
      end
      NORM: begin
        state_d = mag_q[FP_W-1] ? ROUND : NORM;
        mag_d   = mag_q[FP_W-1] ? mag_q : {mag_q[FP_W-2:0], 1'b0};
        exp_d   = mag_q[FP_W-1] ? exp_q : exp_q - 1'b1;
      end
      ROUND: begin
        state_d = DONE;
        data_d  = {sign_q, rnd_exp, rnd_man};
      end
      DONE: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = data_q;
  end
endmodule

// File: tb/tb_itofp_seq.sv
// tb_itofp_seq: scoreboard bench for itofp_seq with directed, backpressure, reset and random stream scenarios.
module tb_itofp_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];

  itofp_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Independent reference: find the MSB, then round the dropped bits against half an ulp.
  function automatic logic [31:0] ref_fp(input logic [31:0] v);
    logic        s;
    logic [31:0] m;
    logic [63:0] man, rem, half;
    int          p, sh, e;
    s = v[31];
    m = s ? -v : v;
    if (m == 0) return 32'h0;
    p = 31;
    while (!m[p]) p--;
    e = 127 + p;
    if (p <= 23) man = 64'(m) << (23 - p);
    else begin
      sh   = p - 23;
      man  = 64'(m) >> sh;
      rem  = 64'(m) & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && man[0])) man++;
      if (man[24]) begin
        man = man >> 1;
        e++;
      end
    end
    return {s, 8'(e), man[22:0]};
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] x;
    x = $urandom >> $urandom_range(0, 31);
    return ($urandom_range(0, 1) != 0) ? -x : x;
  endfunction

  // Drives one operand from IDLE and measures edges after the accept edge until out_valid.
  task automatic convert(input logic [31:0] v, output int lat, output logic [31:0] res, output bit to);
    int w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    to  = !out_valid;
    res = out_data;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
  endtask

  task automatic test_directed();
    logic [31:0] ops[7]  = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'h80000000};
    logic [31:0] want[7] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h4F000000, 32'h4B800000, 32'h4B800002, 32'hCF000000};
    int          lats[7] = '{0, 33, 33, 3, 9, 9, 2};
    int          lat;
    logic [31:0] res, e;
    bit          to;
    for (int i = 0; i < 7; i++) begin
      sb.push_back(want[i]);
      convert(ops[i], lat, res, to);
      e = sb.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL conv_timeout op=%h out_valid=0 want=1", ops[i]); end
      checks++;
      if (res !== e) begin errors++; $display("FAIL conv_data op=%h got=%h want=%h", ops[i], res, e); end
      checks++;
      if (lat != lats[i]) begin errors++; $display("FAIL conv_latency op=%h got=%0d want=%0d", ops[i], lat, lats[i]); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] res;
    bit          to;
    sb.push_back(32'h40A00000);
    convert(32'h5, lat, res, to);
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout out_valid=0 want=1"); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 32'h1234 + i;
      @(posedge clk); #1;
      checks++;
      if (out_data !== sb[0]) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", i, out_data, sb[0]); end
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL bp_hold_flags cyc=%0d got=%b want=10", i, {out_valid, in_ready}); end
    end
    void'(sb.pop_front());
    in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_leave_done got=%b want=10", {in_ready, out_valid}); end
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_no_stray_accept got=%b want=10", {in_ready, out_valid}); end
  endtask

  task automatic test_reset_mid_norm();
    int          lat;
    logic [31:0] res, e;
    bit          to;
    in_valid = 1'b1; in_data = 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midnorm_flags got=%b want=10", {in_ready, out_valid}); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL midnorm_data got=%h want=00000000", out_data); end
    sb.push_back(32'h40400000);
    convert(32'h3, lat, res, to);
    e = sb.pop_front();
    checks++;
    if (to || res !== e) begin errors++; $display("FAIL midnorm_next got=%h want=%h timeout=%0d", res, e, to); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int          sent = 0, got = 0, cyc = 0;
    bit          acc;
    logic [31:0] e;
    in_data = gen(); in_valid = 1'b1; out_ready = 1'b1;
    while (got < 100 && cyc < 6000) begin
      acc = 1'b0;
      if (out_valid) begin
        got++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_unexpected got=%h want=none", out_data); end
        else begin
          e = sb.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL b2b_data n=%0d got=%h want=%h", got, out_data, e); end
        end
      end
      if (in_ready && in_valid) begin
        sb.push_back(ref_fp(in_data));
        sent++;
        acc = 1'b1;
      end
      @(posedge clk); #1; cyc++;
      if (acc) begin
        in_data  = gen();
        in_valid = (sent < 100);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got != 100) begin errors++; $display("FAIL b2b_count got=%0d want=100", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
